time_loader: RTL
================

// Module: time_loader
// PURPOSE
//  Receiving end of the keypad encoder interface. Consumes the BCD key code D, the
//  all-keys-off level 'load' and the 1 Hz tick 'pgt_1Hz'. Assembles the cook time
//  M:SS by shifting in digits, then counts it down once per second.
//  Drives the display digits and the magnetron-on / done outputs of the controller.
// PARAMETERS
//  SYNC_STAGES  2   flops used to synchronise 'load' and 'pgt_1Hz' into clk (>=2)
//  MAX_MIN      9   largest legal minutes digit; entries that would exceed it are dropped
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  clear     in   1  synchronous active-high reset
//  D         in   4  BCD key code from encoder; valid while load==0
//  load      in   1  encoder all-keys-off level: 1 = no key, 0 = key held
//  pgt_1Hz   in   1  1 Hz tick from encoder; rising edge = one second
//  start     in   1  start request, level, edge-detected internally
//  stop      in   1  stop/cancel request, level, edge-detected internally
//  sec_ones  out  4  BCD seconds units
//  sec_tens  out  4  BCD seconds tens (0..5 while running)
//  min_ones  out  4  BCD minutes
//  mag_on    out  1  1 while in RUN
//  done      out  1  1 while in DONE
// BEHAVIOUR
//  - Reset (clear=1): all digits 0, mag_on=0, done=0, state=ENTRY, sync flops = idle (load=1, tick=0).
//  - Key event: a synchronised load 1->0 transition. D is sampled in the same cycle,
//    then acted on one cycle later. Holding a key produces exactly one event.
//  - Tick event: a synchronised pgt_1Hz 0->1 transition. Latency from the pin is SYNC_STAGES+1 clk.
//  - start/stop events: 0->1 edge of the input, registered 1 clk.
//  - States: ENTRY, RUN, PAUSE, DONE.
//   ENTRY: key event with D<=9 shifts left: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
//          D>9 is ignored. A shift that would make min>MAX_MIN is ignored.
//          start with time!=0 -> RUN. start with time==0 stays in ENTRY.
//          stop clears the digits.
//   RUN:   mag_on=1. A tick decrements M:SS in BCD: sec_ones borrows 0->9.
//          sec_tens borrows 0->5; the minutes digit decrements on that borrow.
//          When a tick reaches 0:00 -> DONE in the same cycle. Key events are ignored.
//          stop -> PAUSE.
//   PAUSE: the count is held and ticks are ignored. start -> RUN. stop clears the digits -> ENTRY.
//          Key events are ignored.
//   DONE:  done=1, digits 0:00. A key, start or stop event -> ENTRY with done=0.
//          A key event in DONE is consumed, not shifted.
//  - Entered seconds tens may be 6..9 (e.g. 0:90). On the first tick in RUN, normalise:
//    if sec_tens>5, subtract 6 from sec_tens and add 1 to min, then decrement.
//    Minutes saturate at MAX_MIN.
//  - Simultaneous events in one clk: clear > stop > start > tick > key.
//    Lower-priority events in that cycle are dropped.
//  - clear mid-RUN: mag_on falls in the cycle after clear is sampled.
//  - All BCD digits remain within 0..9 at every cycle.
// STRUCTURE
//  - Shared package (microwave_pkg): state enum {ENTRY,RUN,PAUSE,DONE}, BCD_W=4, BCD_MAX=4'd9,
//    SEC_TENS_MAX=4'd5, key code for 'none' (4'hF).
//  - One sub-module: edge_sync (SYNC_STAGES-flop synchroniser + rising/falling pulse),
//    instantiated for load and pgt_1Hz.
//  - BCD decrement-with-borrow is a function in the package.
//  - The FSM and the digit registers sit in this module.
// TESTING
//  - clear, then keys 1,3,0 (load low 5 clk each) -> digits 1:30, mag_on=0.
//  - 1:30, start, 3 ticks -> 1:27. Tick 31 after start gives 0:59.
//  - 0:02 running, 2 ticks -> 0:00, done=1, mag_on=0. A key event then gives done=0 and ENTRY
//    with 0:00.
//  - Key held for 100 clk -> one shift only. Key code D=4'hA -> no change.
//  - start and tick in the same clk in ENTRY at 0:05 -> RUN, count still 0:05. Tick next
//    second -> 0:04.
//  - RUN at 0:45, stop -> PAUSE; ticks hold 0:45. Second stop -> 0:00 ENTRY.
//    clear during RUN -> all outputs 0 next clk.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave controller.
//  state_t      : controller state encoding
//  bcd_time_t   : displayed cook time M:SS as three BCD digits
//  bcd_dec      : one-digit BCD decrement with borrow out
package microwave_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] KEY_NONE     = 4'hF;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_time_t;

  typedef struct packed {
    logic             borrow;
    logic [BCD_W-1:0] digit;
  } bcd_dec_t;

  // Decrement one digit; 0 wraps to 'wrap' and raises borrow.
  function automatic bcd_dec_t bcd_dec(input logic [BCD_W-1:0] d,
                                       input logic [BCD_W-1:0] wrap);
    bcd_dec_t r;
    if (d == '0) begin
      r.borrow = 1'b1;
      r.digit  = wrap;
    end else begin
      r.borrow = 1'b0;
      r.digit  = d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser followed by a single-cycle edge pulse.
//  clk, clear : clock and synchronous active-high reset
//  din        : asynchronous input level
//  pulse_c    : one-clk pulse on the selected edge of the synchronised level
module edge_sync #(
  parameter int unsigned STAGES = 2,
  parameter bit          IDLE   = 1'b0,
  parameter bit          RISING = 1'b1
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic pulse_c
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync <= {STAGES{IDLE}};
      prev <= IDLE;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign pulse_c = RISING ? (sync[STAGES-1] & ~prev) : (~sync[STAGES-1] & prev);

endmodule

// File: rtl/time_loader.sv
// Cook-time entry and countdown for the microwave controller.
//  clk, clear          : clock and synchronous active-high reset
//  D, load             : keypad BCD code and all-keys-off level (0 = key held)
//  pgt_1Hz             : 1 Hz tick, rising edge = one second
//  start, stop         : level requests, edge-detected here
//  sec_ones, sec_tens,
//  min_ones            : displayed BCD time M:SS
//  mag_on, done        : high in RUN / DONE respectively
module time_loader import microwave_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 9
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [BCD_W-1:0] D,
  input  logic             load,
  input  logic             pgt_1Hz,
  input  logic             start,
  input  logic             stop,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic             mag_on,
  output logic             done
);

  localparam logic [BCD_W-1:0] MIN_LIMIT = BCD_W'(MAX_MIN);

  logic             key_ev_c;
  logic             tick_ev_c;
  logic             start_prev, stop_prev;
  logic             start_ev, stop_ev;
  logic             key_pend;
  logic [BCD_W-1:0] key_code;

  state_t    state, state_nxt;
  bcd_time_t cnt, cnt_nxt;

  // Key event is the synchronised falling edge of load.
  edge_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1), .RISING(1'b0)) u_load_sync (
    .clk    (clk),
    .clear  (clear),
    .din    (load),
    .pulse_c(key_ev_c)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0), .RISING(1'b1)) u_tick_sync (
    .clk    (clk),
    .clear  (clear),
    .din    (pgt_1Hz),
    .pulse_c(tick_ev_c)
  );

  // State, digits, registered outputs and event capture.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ENTRY;
      cnt        <= '0;
      mag_on     <= 1'b0;
      done       <= 1'b0;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      start_ev   <= 1'b0;
      stop_ev    <= 1'b0;
      key_pend   <= 1'b0;
      key_code   <= KEY_NONE;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mag_on     <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      start_prev <= start;
      stop_prev  <= stop;
      start_ev   <= start & ~start_prev;
      stop_ev    <= stop & ~stop_prev;
      // D is captured with the key event and acted on the following cycle.
      key_pend   <= key_ev_c;
      key_code   <= key_ev_c ? D : KEY_NONE;
    end
  end

  bcd_time_t norm, tick_cnt, shifted;
  bcd_dec_t  dec_ones, dec_tens, dec_min;
  logic      cnt_zero, tick_zero, shift_ok;

  // Next time on a tick: fold entered tens >5 into minutes, then decrement.
  always_comb begin
    norm = cnt;
    if (cnt.tens > SEC_TENS_MAX) begin
      norm.tens = cnt.tens - 4'd6;
      norm.min  = (cnt.min >= MIN_LIMIT) ? MIN_LIMIT : cnt.min + 4'd1;
    end
    dec_ones      = bcd_dec(norm.ones, BCD_MAX);
    dec_tens      = bcd_dec(norm.tens, SEC_TENS_MAX);
    dec_min       = bcd_dec(norm.min, BCD_MAX);
    tick_cnt.ones = dec_ones.digit;
    tick_cnt.tens = dec_ones.borrow ? dec_tens.digit : norm.tens;
    tick_cnt.min  = (dec_ones.borrow && dec_tens.borrow) ? dec_min.digit : norm.min;
    tick_zero     = (tick_cnt == '0);
    cnt_zero      = (cnt == '0);
    shifted       = '{min: cnt.tens, tens: cnt.ones, ones: key_code};
    shift_ok      = (key_code <= BCD_MAX) && (cnt.tens <= MIN_LIMIT);
  end

  // Next-state: priority stop > start > tick > key within each state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ENTRY: begin
        if (stop_ev) begin
          cnt_nxt = '0;
        end else if (start_ev) begin
          if (!cnt_zero) state_nxt = RUN;
        end else if (tick_ev_c) begin
          state_nxt = ENTRY;
        end else if (key_pend && shift_ok) begin
          cnt_nxt = shifted;
        end
      end
      RUN: begin
        if (stop_ev) begin
          state_nxt = PAUSE;
        end else if (start_ev) begin
          state_nxt = RUN;
        end else if (tick_ev_c) begin
          cnt_nxt = tick_cnt;
          if (tick_zero) state_nxt = DONE;
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          cnt_nxt   = '0;
          state_nxt = ENTRY;
        end else if (start_ev) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        cnt_nxt = '0;
        if (stop_ev || start_ev || key_pend) state_nxt = ENTRY;
      end
      default: begin
        state_nxt = ENTRY;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign sec_ones = cnt.ones;
  assign sec_tens = cnt.tens;
  assign min_ones = cnt.min;

endmodule
